quiz_referee: RTL

- Clocked, parametrised successor of the two-player quiz top level.
- Accepts raw active-low answer buttons for NUM_PLAYERS players with NUM_CHOICES choices each.
- Arbitrates the first press, checks it against the current question's answer, and keeps per-player scores.
- Advances the question index, locks out wrong answerers, and declares a winner with a timed beep. Question/answer ROM and LED display drivers sit outside this block.

---
 rtl/quiz_pkg.sv | 40 ++++
 rtl/quiz_referee_if.sv | 33 +++
 rtl/quiz_press_arbiter.sv | 63 ++++++
 rtl/quiz_referee.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz referee: FSM state encoding,
// width helpers and score-to-thermometer conversion.
package quiz_pkg;

  typedef enum logic [1:0] {
    ASK      = 2'd0,
    WAIT_REL = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam int unsigned SCORE_W  = 4;
  localparam int unsigned THERMO_W = 15;

  localparam int unsigned DEF_NUM_CHOICES   = 4;
  localparam int unsigned DEF_NUM_QUESTIONS = 10;

  // Minimum bit width able to index v distinct values; never returns 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned CW = clog2(DEF_NUM_CHOICES + 1);
  localparam int unsigned QW = clog2(DEF_NUM_QUESTIONS);

  function automatic logic [THERMO_W-1:0] thermo(input logic [SCORE_W-1:0] score,
                                                 input int unsigned        win);
    logic [THERMO_W-1:0] t;
    t = '0;
    for (int unsigned k = 0; k < THERMO_W; k++) begin
      t[k] = (k < win) && (32'(score) > k);
    end
    return t;
  endfunction

endpackage

// File: rtl/quiz_referee_if.sv
// Button inputs and display/status outputs of the quiz referee.
interface quiz_referee_if
  import quiz_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_CHOICES   = 4,
  parameter int unsigned NUM_QUESTIONS = 10,
  parameter int unsigned WIN_SCORE     = 5
);
  localparam int unsigned CW_L = clog2(NUM_CHOICES + 1);
  localparam int unsigned QW_L = clog2(NUM_QUESTIONS);

  logic [NUM_PLAYERS*NUM_CHOICES-1:0] in_joy;
  logic [CW_L-1:0]                    in_ans;
  logic                               in_restart;
  logic [QW_L-1:0]                    q_idx;
  logic [NUM_PLAYERS*WIN_SCORE-1:0]   led_score;
  logic [NUM_PLAYERS-1:0]             lock;
  logic [NUM_PLAYERS-1:0]             winner;
  logic                               beep;
  logic                               busy_wait;

  modport master (
    output in_joy, in_ans, in_restart,
    input  q_idx, led_score, lock, winner, beep, busy_wait
  );

  modport slave (
    input  in_joy, in_ans, in_restart,
    output q_idx, led_score, lock, winner, beep, busy_wait
  );

endinterface

// File: rtl/quiz_press_arbiter.sv
// Detects a fresh press after an all-released cycle, masks locked players,
// picks the lowest eligible player and decodes that player's choice.
module quiz_press_arbiter
  import quiz_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS = 2,
  parameter  int unsigned NUM_CHOICES = 4,
  localparam int unsigned CW_L        = clog2(NUM_CHOICES + 1),
  localparam int unsigned PW_L        = clog2(NUM_PLAYERS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PLAYERS*NUM_CHOICES-1:0] joy_i,
  input  logic [NUM_PLAYERS-1:0]             lock_i,
  input  logic                               arm_i,
  output logic                               press_vld_o,
  output logic [PW_L-1:0]                    press_player_o,
  output logic [CW_L-1:0]                    press_choice_o,
  output logic                               press_multi_o
);

  logic                   all_rel_q;
  logic                   found;
  logic [NUM_CHOICES-1:0] grp;
  logic [CW_L-1:0]        ch;
  int unsigned            lows;

  // Reset clears the history so a button held through reset needs a release.
  always_ff @(posedge clk) begin
    if (!rst_n) all_rel_q <= 1'b0;
    else        all_rel_q <= &joy_i;
  end

  // Descending scan so the lowest eligible player index wins.
  always_comb begin
    found          = 1'b0;
    grp            = '1;
    ch             = '0;
    lows           = 0;
    press_player_o = '0;
    press_choice_o = '0;
    press_multi_o  = 1'b0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      grp = joy_i[p*NUM_CHOICES +: NUM_CHOICES];
      if (!lock_i[p] && !(&grp)) begin
        found = 1'b1;
        lows  = 0;
        ch    = '0;
        for (int c = 0; c < NUM_CHOICES; c++) begin
          if (!grp[c]) begin
            lows = lows + 1;
            ch   = CW_L'(c + 1);
          end
        end
        press_player_o = PW_L'(p);
        press_choice_o = ch;
        press_multi_o  = (lows > 1);
      end
    end
    press_vld_o = arm_i && all_rel_q && !(&joy_i) && found;
  end

endmodule

// File: rtl/quiz_referee.sv
// Quiz referee: judges arbitrated presses, keeps scores, lockouts and the
// question index, and declares the winner with a timed beep.
module quiz_referee
  import quiz_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_CHOICES   = 4,
  parameter int unsigned NUM_QUESTIONS = 10,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned BEEP_CYCLES   = 1000
) (
  input logic           clk,
  input logic           rst_n,
  quiz_referee_if.slave bus
);

  localparam int unsigned CW_L = clog2(NUM_CHOICES + 1);
  localparam int unsigned QW_L = clog2(NUM_QUESTIONS);
  localparam int unsigned PW_L = clog2(NUM_PLAYERS);
  localparam int unsigned BW_L = clog2(BEEP_CYCLES + 1);
  localparam int unsigned LW_L = NUM_PLAYERS * WIN_SCORE;

  state_e                              state_q, state_d;
  logic [QW_L-1:0]                     q_q, q_d, q_next;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [NUM_PLAYERS-1:0]              lock_q, lock_d, lock_set;
  logic [NUM_PLAYERS-1:0]              winner_q, winner_d;
  logic                                beep_q, beep_d;
  logic [BW_L-1:0]                     cnt_q, cnt_d;
  logic [LW_L-1:0]                     led_q, led_d;
  logic                                busy_q, busy_d;
  logic [THERMO_W-1:0]                 t;

  logic               press_vld, press_multi, hit, win;
  logic [PW_L-1:0]    press_player;
  logic [CW_L-1:0]    press_choice;
  logic [SCORE_W-1:0] inc_score;

  quiz_press_arbiter #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .NUM_CHOICES (NUM_CHOICES)
  ) u_arb (
    .clk            (clk),
    .rst_n          (rst_n),
    .joy_i          (bus.in_joy),
    .lock_i         (lock_q),
    .arm_i          (state_q == ASK),
    .press_vld_o    (press_vld),
    .press_player_o (press_player),
    .press_choice_o (press_choice),
    .press_multi_o  (press_multi)
  );

  // Out-of-range answers never equal a decoded choice, so they always miss.
  assign hit       = press_vld && !press_multi && (press_choice == bus.in_ans);
  assign inc_score = score_q[press_player] + SCORE_W'(1);
  assign win       = hit && (32'(inc_score) == WIN_SCORE);
  assign q_next    = (q_q == QW_L'(NUM_QUESTIONS - 1)) ? '0 : q_q + QW_L'(1);
  assign lock_set  = lock_q | (NUM_PLAYERS'(1) << press_player);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ASK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ASK:      if (press_vld) state_d = win ? DONE : WAIT_REL;
      WAIT_REL: if (&bus.in_joy) state_d = ASK;
      DONE:     if (bus.in_restart) state_d = WAIT_REL;
      default:  state_d = ASK;
    endcase
  end

  always_comb begin
    q_d      = q_q;
    score_d  = score_q;
    lock_d   = lock_q;
    winner_d = winner_q;
    beep_d   = beep_q;
    cnt_d    = cnt_q;
    t        = '0;
    led_d    = '0;
    case (state_q)
      ASK: begin
        if (press_vld && hit) begin
          score_d[press_player] = inc_score;
          lock_d                = '0;
          q_d                   = q_next;
          if (win) begin
            winner_d = NUM_PLAYERS'(1) << press_player;
            beep_d   = 1'b1;
            cnt_d    = BW_L'(BEEP_CYCLES - 1);
          end
        end else if (press_vld) begin
          // Everyone locked out skips the question with no score change.
          if (&lock_set) begin
            lock_d = '0;
            q_d    = q_next;
          end else begin
            lock_d = lock_set;
          end
        end
      end
      DONE: begin
        if (bus.in_restart) begin
          score_d  = '0;
          lock_d   = '0;
          q_d      = '0;
          winner_d = '0;
          beep_d   = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - BW_L'(1);
        end else begin
          beep_d = 1'b0;
        end
      end
      default: ;
    endcase
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      t = thermo(score_d[p], WIN_SCORE);
      led_d[p*WIN_SCORE +: WIN_SCORE] = t[WIN_SCORE-1:0];
    end
    busy_d = (state_d == WAIT_REL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q      <= '0;
      score_q  <= '0;
      lock_q   <= '0;
      winner_q <= '0;
      beep_q   <= 1'b0;
      cnt_q    <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      score_q  <= score_d;
      lock_q   <= lock_d;
      winner_q <= winner_d;
      beep_q   <= beep_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.q_idx     = q_q;
  assign bus.led_score = led_q;
  assign bus.lock      = lock_q;
  assign bus.winner    = winner_q;
  assign bus.beep      = beep_q;
  assign bus.busy_wait = busy_q;

endmodule
